reg_scoreboard: RTL

- Issue-side scheduler for the 32x32 register file in the 5-stage pipeline.
- Tracks outstanding writes per architectural register with per-register in-flight counters.
- Stalls decode while any source or destination operand is not yet safe to read or allocate.
- Retires entries on writeback or pipeline kill, and keeps a stall-cycle performance counter and a sticky underflow error flag.

---
 rtl/reg_scoreboard.sv | 98 +++++++++
 1 files changed

// File: rtl/reg_scoreboard.sv
// Register-file write scoreboard: per-register in-flight write counters that stall decode
// on RAW hazards and on a full destination counter, with a stall-cycle counter and an underflow flag.
module reg_scoreboard #(
   parameter int unsigned CNT_W     = 2,
   parameter bit          WB_BYPASS = 1'b1,
   parameter int unsigned PERF_W    = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              issue_valid,
   input  logic [4:0]        issue_rs1,
   input  logic [4:0]        issue_rs2,
   input  logic              issue_use_rs1,
   input  logic              issue_use_rs2,
   input  logic [4:0]        issue_rd,
   input  logic              issue_writes_rd,
   input  logic              wb_valid,
   input  logic [4:0]        wb_rd,
   input  logic              kill_valid,
   input  logic [4:0]        kill_rd,
   output logic              stall,
   output logic              issue_accept,
   output logic [31:0]       busy_vec,
   output logic [PERF_W-1:0] stall_count,
   output logic              underflow_err
);

   // Wide enough to hold cnt + inc and compare against a 2-bit decrement
   localparam int unsigned SW = CNT_W + 2;

   logic [CNT_W-1:0]  cnt_q [32];
   logic [CNT_W-1:0]  cnt_d [32];
   logic [31:0]       busy_q, busy_d;
   logic [PERF_W-1:0] stall_count_q, stall_count_d;
   logic              underflow_q, underflow_d;
   logic              haz_rs1, haz_rs2, rd_full;

   // A writeback draining the last pending write makes the source safe this cycle
   always_comb begin
      haz_rs1 = issue_use_rs1 && (issue_rs1 != 5'd0) && (cnt_q[issue_rs1] != '0) &&
                !(WB_BYPASS && wb_valid && (wb_rd == issue_rs1) &&
                  (cnt_q[issue_rs1] == CNT_W'(1)));
      haz_rs2 = issue_use_rs2 && (issue_rs2 != 5'd0) && (cnt_q[issue_rs2] != '0) &&
                !(WB_BYPASS && wb_valid && (wb_rd == issue_rs2) &&
                  (cnt_q[issue_rs2] == CNT_W'(1)));
      rd_full = issue_writes_rd && (issue_rd != 5'd0) && (cnt_q[issue_rd] == '1);
      stall        = !reset && issue_valid && (haz_rs1 || haz_rs2 || rd_full);
      issue_accept = !reset && issue_valid && !stall;
   end

   always_comb begin
      logic          inc, wb_hit, kill_hit;
      logic [1:0]    dec;
      logic [SW-1:0] sum, decw;
      cnt_d       = cnt_q;
      busy_d      = '0;
      underflow_d = underflow_q;
      cnt_d[0]    = '0;
      for (int r = 1; r < 32; r++) begin
         inc      = issue_accept && issue_writes_rd && (issue_rd == 5'(r));
         wb_hit   = wb_valid && (wb_rd == 5'(r));
         kill_hit = kill_valid && (kill_rd == 5'(r));
         dec      = {1'b0, wb_hit} + {1'b0, kill_hit};
         sum      = SW'(cnt_q[r]) + SW'(inc);
         decw     = SW'(dec);
         if (decw > sum) begin
            cnt_d[r]    = '0;
            underflow_d = 1'b1;
         end else begin
            cnt_d[r] = CNT_W'(sum - decw);
         end
         busy_d[r] = (cnt_d[r] != '0);
      end
      stall_count_d = stall_count_q;
      if (issue_valid && stall && (stall_count_q != '1)) begin
         stall_count_d = stall_count_q + PERF_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int r = 0; r < 32; r++) cnt_q[r] <= '0;
         busy_q        <= '0;
         stall_count_q <= '0;
         underflow_q   <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         busy_q        <= busy_d;
         stall_count_q <= stall_count_d;
         underflow_q   <= underflow_d;
      end
   end

   assign busy_vec      = busy_q;
   assign stall_count   = stall_count_q;
   assign underflow_err = underflow_q;

endmodule
